// File: rtl/memacc_pkg.sv
// memacc_pkg: shared types and helpers for the load/store unit.
`default_nettype none

package memacc_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam int ROW_BYTES = 8;
  localparam int LANE_W    = $clog2(ROW_BYTES);

  function automatic logic [3:0] size_bytes(input size_e sz);
    return 4'd1 << sz;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_lane_merge.sv
// lane_merge: combinational byte-lane insert for stores and extract/extend for loads.
`default_nettype none

module lane_merge
  import memacc_pkg::*;
(
  input  logic [63:0]       row,
  input  logic [LANE_W-1:0] lane,
  input  size_e             size,
  input  logic              sign_ext,
  input  logic [63:0]       wdata,
  output logic [63:0]       merged,
  output logic [63:0]       extracted
);

  logic [5:0]  shamt;
  logic [63:0] size_mask;
  logic [63:0] shifted;

  assign shamt = {lane, 3'b000};

  always_comb begin
    size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    case (size)
      SZ_B:    size_mask = 64'h0000_0000_0000_00FF;
      SZ_H:    size_mask = 64'h0000_0000_0000_FFFF;
      SZ_W:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  // A full-width access has an all-ones mask, so the stale row never leaks through.
  assign merged  = (row & ~(size_mask << shamt)) | ((wdata & size_mask) << shamt);
  assign shifted = row >> shamt;

  always_comb begin
    extracted = shifted;
    case (size)
      SZ_B:    extracted = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
      SZ_H:    extracted = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
      SZ_W:    extracted = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
      default: extracted = shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// mem_access_unit: B/H/W/D load/store controller with read-modify-write for sub-word stores.
// Optional MISALIGN_TRAP_EN: fault misaligned requests instead of aligning them down.
`default_nettype none

module mem_access_unit
  import memacc_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int ROW_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_we,
  output logic [63:0]       mem_a,
  output logic [63:0]       mem_wd,
  input  logic [63:0]       mem_rd
);

  state_e state, state_nxt;

  logic              lat_we;
  size_e             lat_size;
  logic              lat_signed;
  logic [ROW_W-1:0]  lat_row;
  logic [LANE_W-1:0] lat_lane;
  logic [63:0]       lat_wdata;
  logic [63:0]       row_buf;
  logic [63:0]       rdata;

  size_e             in_size;
  logic [3:0]        in_nbytes;
  logic [LANE_W-1:0] low_mask;
  logic [LANE_W-1:0] lane_aligned;
  logic              in_misaligned;
  logic              unused_addr_bits;

  logic [63:0] merge_row;
  logic [63:0] merged;
  logic [63:0] extracted;

  assign in_size       = size_e'(req_size);
  assign in_nbytes     = size_bytes(in_size);
  assign low_mask      = LANE_W'(in_nbytes - 4'd1);
  assign lane_aligned  = req_addr[LANE_W-1:0] & ~low_mask;
  assign in_misaligned = |(req_addr[LANE_W-1:0] & low_mask);
  // Bits above the row field wrap; they never reach the memory.
  assign unused_addr_bits = ^req_addr[ADDR_W-1:LANE_W+ROW_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
`ifdef MISALIGN_TRAP_EN
          if (in_misaligned)
            state_nxt = RESP;
          else
`endif
          if (req_we && in_size == SZ_D)
            state_nxt = WR;
          else
            state_nxt = RD;
        end
      end
      RD:      state_nxt = lat_we ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we     <= 1'b0;
      lat_size   <= SZ_B;
      lat_signed <= 1'b0;
      lat_row    <= '0;
      lat_lane   <= '0;
      lat_wdata  <= '0;
      row_buf    <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we     <= req_we;
            lat_size   <= in_size;
            lat_signed <= req_signed;
            lat_row    <= req_addr[LANE_W +: ROW_W];
            lat_lane   <= lane_aligned;
            lat_wdata  <= req_wdata;
            rdata      <= '0;
          end
        end
        RD: begin
          row_buf <= mem_rd;
          if (!lat_we) rdata <= extracted;
        end
        default: ;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        fault <= 1'b0;
    else if (state == IDLE && req_valid) fault <= in_misaligned;
  end

  assign resp_fault = fault;
`else
  logic unused_misaligned;
  assign unused_misaligned = in_misaligned;
  assign resp_fault        = 1'b0;
`endif

  // Loads extract straight from the memory read; stores merge into the captured row.
  assign merge_row = (state == RD) ? mem_rd : row_buf;

  lane_merge u_lane_merge (
    .row       (merge_row),
    .lane      (lat_lane),
    .size      (lat_size),
    .sign_ext  (lat_signed),
    .wdata     (lat_wdata),
    .merged    (merged),
    .extracted (extracted)
  );

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata;
  assign mem_we     = (state == WR);
  assign mem_wd     = (state == WR) ? merged : 64'd0;
  assign mem_a      = {{(64 - ROW_W - 2){1'b0}}, lat_row, 2'b00};

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven checks of the load/store unit against a row-array memory.
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [63:0] mem_a;
  logic [63:0] mem_wd;
  logic [63:0] mem_rd;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  logic [63:0] mem [0:63];
  int we_total = 0;

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
      we_total++;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    int          exp_lat;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [18];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic we, input logic [1:0] size, input logic sgn,
                      input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [63:0] exp_rdata, input int exp_lat, input logic exp_fault);
    vecs[i].we        = we;
    vecs[i].size      = size;
    vecs[i].sgn       = sgn;
    vecs[i].addr      = addr;
    vecs[i].wdata     = wdata;
    vecs[i].exp_rdata = exp_rdata;
    vecs[i].exp_lat   = exp_lat;
    vecs[i].exp_fault = exp_fault;
  endtask

  task automatic do_req(input int i);
    int lat;
    int we_start;
    logic [63:0] exp_a;
    exp_a = {56'd0, vecs[i].addr[8:3], 2'b00};
    @(negedge clk);
    we_start   = we_total;
    req_valid  = 1'b1;
    req_we     = vecs[i].we;
    req_size   = vecs[i].size;
    req_signed = vecs[i].sgn;
    req_addr   = vecs[i].addr;
    req_wdata  = vecs[i].wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("v%0d resp_valid", i), 64'(resp_valid), 64'd1);
    chk($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
    chk($sformatf("v%0d rdata", i), resp_rdata, vecs[i].exp_rdata);
    chk($sformatf("v%0d fault", i), 64'(resp_fault), 64'(vecs[i].exp_fault));
    chk($sformatf("v%0d mem_we pulses", i), 64'(we_total - we_start),
        64'((vecs[i].we && !vecs[i].exp_fault) ? 1 : 0));
    if (!vecs[i].exp_fault) chk($sformatf("v%0d mem_a", i), mem_a, exp_a);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk($sformatf("v%0d ready after handshake", i), 64'(req_ready), 64'd1);
  endtask

  initial begin
    int t;
    int we_snap;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    setv(0,  1, 2'd3, 0, 64'h40,   64'h1122334455667788, 64'h0, 2, 0);
    setv(1,  0, 2'd3, 0, 64'h40,   64'h0, 64'h1122334455667788, 2, 0);
    setv(2,  1, 2'd0, 0, 64'h43,   64'hFFFFFFFFFFFFFFAB, 64'h0, 3, 0);
    setv(3,  0, 2'd3, 0, 64'h40,   64'h0, 64'h11223344AB667788, 2, 0);
`ifdef MISALIGN_TRAP_EN
    setv(4,  0, 2'd2, 0, 64'h42,   64'h0, 64'h0, 1, 1);
`else
    setv(4,  0, 2'd2, 0, 64'h42,   64'h0, 64'h00000000AB667788, 2, 0);
`endif
    setv(5,  0, 2'd0, 1, 64'h43,   64'h0, 64'hFFFFFFFFFFFFFFAB, 2, 0);
    setv(6,  0, 2'd1, 0, 64'h44,   64'h0, 64'h0000000000003344, 2, 0);
    setv(7,  1, 2'd3, 0, 64'h40,   64'h8000000000000000, 64'h0, 2, 0);
    setv(8,  0, 2'd1, 1, 64'h46,   64'h0, 64'hFFFFFFFFFFFF8000, 2, 0);
    setv(9,  0, 2'd1, 0, 64'h46,   64'h0, 64'h0000000000008000, 2, 0);
    setv(10, 0, 2'd0, 1, 64'h47,   64'h0, 64'hFFFFFFFFFFFFFF80, 2, 0);
    setv(11, 1, 2'd3, 0, 64'h100,  64'h0, 64'h0, 2, 0);
    setv(12, 1, 2'd1, 0, 64'h102,  64'h1234BEEF, 64'h0, 3, 0);
    setv(13, 0, 2'd2, 1, 64'h100,  64'h0, 64'hFFFFFFFFBEEF0000, 2, 0);
    setv(14, 0, 2'd2, 0, 64'h1100, 64'h0, 64'h00000000BEEF0000, 2, 0);
    setv(15, 0, 2'd3, 1, 64'h100,  64'h0, 64'h00000000BEEF0000, 2, 0);
    setv(16, 1, 2'd2, 0, 64'h104,  64'hCAFEF00D, 64'h0, 3, 0);
    setv(17, 0, 2'd3, 0, 64'h100,  64'h0, 64'hCAFEF00DBEEF0000, 2, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready",  64'(req_ready),  64'd1);
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset resp_rdata", resp_rdata,      64'd0);
    chk("reset resp_fault", 64'(resp_fault), 64'd0);
    chk("reset mem_we",     64'(mem_we),     64'd0);
    chk("reset mem_a",      mem_a,           64'd0);
    chk("reset mem_wd",     mem_wd,          64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) do_req(i);

    // Response held under back-pressure while a second request is presented.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_addr = 64'h40;
    @(posedge clk);
    #1;
    req_addr = 64'h100;
    t = 0;
    while (!resp_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("stall first resp_valid", 64'(resp_valid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall c%0d resp_valid", c), 64'(resp_valid), 64'd1);
      chk($sformatf("stall c%0d rdata", c), resp_rdata, 64'h8000000000000000);
      chk($sformatf("stall c%0d req_ready", c), 64'(req_ready), 64'd0);
      chk($sformatf("stall c%0d mem_a", c), mem_a, 64'h20);
    end
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("stall release req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("stall second not accepted", 64'(resp_valid), 64'd0);

    // Reset asserted during the write cycle of a read-modify-write.
    @(negedge clk);
    we_snap = we_total;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 64'h40; req_wdata = 64'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort mem_we in WR", 64'(mem_we), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort mem_we dropped", 64'(mem_we), 64'd0);
    chk("abort req_ready", 64'(req_ready), 64'd1);
    chk("abort resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort no write", 64'(we_total - we_snap), 64'd0);
    setv(0, 0, 2'd3, 0, 64'h40, 64'h0, 64'h8000000000000000, 2, 0);
    do_req(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
